tt_uio_arbiter: RTL

- Shares the 8 bidirectional uio pins (uio_out/uio_oe/uio_in) of the tt_um top between N_REQ internal requesters.
- One requester owns the pins at a time. Arbitration is round-robin.
- A forced all-input turnaround of TURNAROUND cycles separates owners, so no two drivers overlap.
- A hold limit preempts owners that keep the pins too long.
- Sits directly under the tt_um top, between user logic and the uio pads.

---
 rtl/tt_uio_arb_pkg.sv | 26 ++
 rtl/tt_uio_arbiter_pick.sv | 47 ++++
 rtl/tt_uio_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tt_uio_arb_pkg.sv
// Shared types, widths and helpers for the uio pin arbiter.
// TT_UIO_ARB_PRIO_EN selects fixed-priority picking in place of round-robin.
package tt_uio_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TURN,
    ST_OWN
  } arb_state_e;

  localparam int PIN_W   = 8;
  localparam int MAX_REQ = 4;
  localparam int IDX_W   = $clog2(MAX_REQ);

  // Counters are sized for the largest legal HOLD_MAX / TURNAROUND.
  localparam int HOLD_LIMIT = 255;
  localparam int TURN_LIMIT = 3;
  localparam int HOLD_W     = $clog2(HOLD_LIMIT + 1);
  localparam int TURN_W     = $clog2(TURN_LIMIT + 1);

  function automatic logic [PIN_W-1:0] pin_slice(input logic [PIN_W*MAX_REQ-1:0] bus,
                                                 input logic [IDX_W-1:0]         idx);
    return PIN_W'(bus >> (idx * PIN_W));
  endfunction

endpackage

// File: rtl/tt_uio_arbiter_pick.sv
// Combinational winner picker: round-robin after last_owner, or lowest index
// when TT_UIO_ARB_PRIO_EN is defined.
module tt_rr_pick
  import tt_uio_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  logic [N_REQ-1:0] cand;

`ifdef TT_UIO_ARB_PRIO_EN
  logic unused_last;
  assign unused_last = ^last_owner;

  always_comb begin
    winner = '0;
    cand   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = N_REQ'(1) << i;
      if (|(req & cand)) winner = cand;
    end
  end
`else
  int idx;

  // Walk downward so the requester nearest after last_owner wins last.
  always_comb begin
    winner = '0;
    cand   = '0;
    idx    = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(last_owner) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = N_REQ'(1) << idx;
      if (|(req & cand)) winner = cand;
    end
  end
`endif

  assign valid = |req;

endmodule

// File: rtl/tt_uio_arbiter.sv
// Shares the 8 uio pins between N_REQ requesters with a forced all-input turnaround.
// Define TT_UIO_ARB_PRIO_EN for fixed-priority arbitration and preemption.
module tt_uio_arbiter
  import tt_uio_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int HOLD_MAX   = 15,
  parameter int TURNAROUND = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       rel,
  input  logic [PIN_W*N_REQ-1:0] req_out,
  input  logic [PIN_W*N_REQ-1:0] req_oe,
  input  logic [PIN_W-1:0]       uio_in,
  output logic [PIN_W-1:0]       uio_out,
  output logic [PIN_W-1:0]       uio_oe,
  output logic [N_REQ-1:0]       gnt,
  output logic [PIN_W-1:0]       rd_data,
  output logic                   busy
);

  arb_state_e state, next_state;
  logic [IDX_W-1:0]  owner, next_owner, last_owner, next_last, pick_last, pick_idx;
  logic [TURN_W-1:0] turn_cnt, next_turn;
  logic [HOLD_W-1:0] hold_cnt, next_hold;
  logic [N_REQ-1:0]  own_mask, others, pick_req, pick_onehot;
  logic              pick_valid, own_req, own_rel, preempt, leave;
  logic [PIN_W*MAX_REQ-1:0] out_bus, oe_bus;

  assign own_mask = N_REQ'(1) << owner;
  assign others   = req & ~own_mask;
  assign own_req  = |(req & own_mask);
  assign own_rel  = |(rel & own_mask);

`ifdef TT_UIO_ARB_PRIO_EN
  assign preempt = (hold_cnt == HOLD_W'(HOLD_MAX)) && |(req & (own_mask - N_REQ'(1)));
`else
  assign preempt = (hold_cnt == HOLD_W'(HOLD_MAX)) && |others;
`endif
  assign leave = own_rel || !own_req || preempt;

  // While leaving OWN the current owner is masked out so it cannot re-win at once.
  assign pick_req  = (state == ST_OWN) ? others : req;
  assign pick_last = (state == ST_OWN) ? owner  : last_owner;

  tt_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (pick_req),
    .last_owner (pick_last),
    .winner     (pick_onehot),
    .valid      (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (|(pick_onehot & (N_REQ'(1) << i))) pick_idx = IDX_W'(i);
  end

  always_comb begin
    out_bus = '0;
    oe_bus  = '0;
    out_bus[PIN_W*N_REQ-1:0] = req_out;
    oe_bus[PIN_W*N_REQ-1:0]  = req_oe;
  end

  always_comb begin
    next_state = state;
    next_owner = owner;
    next_last  = last_owner;
    next_turn  = turn_cnt;
    next_hold  = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          next_state = ST_TURN;
          next_owner = pick_idx;
          next_turn  = TURN_W'(TURNAROUND);
        end
      end
      ST_TURN: begin
        if (req == '0) begin
          next_state = ST_IDLE;
        end else if (turn_cnt <= TURN_W'(1)) begin
          next_state = ST_OWN;
          next_hold  = HOLD_W'(1);
          if (!own_req) next_owner = pick_idx;
        end else begin
          next_turn = turn_cnt - TURN_W'(1);
        end
      end
      ST_OWN: begin
        if (leave) begin
          next_last = owner;
          next_hold = '0;
          if (pick_valid) begin
            next_state = ST_TURN;
            next_owner = pick_idx;
            next_turn  = TURN_W'(TURNAROUND);
          end else begin
            next_state = ST_IDLE;
          end
        end else if (hold_cnt < HOLD_W'(HOLD_MAX)) begin
          next_hold = hold_cnt + HOLD_W'(1);
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Pin outputs register alongside gnt, so the first OWN cycle already drives the owner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(N_REQ - 1);
      turn_cnt   <= '0;
      hold_cnt   <= '0;
      uio_out    <= '0;
      uio_oe     <= '0;
      gnt        <= '0;
      rd_data    <= '0;
    end else if (!ena) begin
      state    <= ST_IDLE;
      turn_cnt <= '0;
      hold_cnt <= '0;
      uio_out  <= '0;
      uio_oe   <= '0;
      gnt      <= '0;
    end else begin
      state      <= next_state;
      owner      <= next_owner;
      last_owner <= next_last;
      turn_cnt   <= next_turn;
      hold_cnt   <= next_hold;
      if (state == ST_OWN) rd_data <= uio_in;
      if (next_state == ST_OWN) begin
        uio_out <= pin_slice(out_bus, next_owner);
        uio_oe  <= pin_slice(oe_bus, next_owner);
        gnt     <= N_REQ'(1) << next_owner;
      end else begin
        uio_out <= '0;
        uio_oe  <= '0;
        gnt     <= '0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
